// File: rtl/uart_pkg.sv
// Shared types and constants for the buffered UART bridge.
package uart_pkg;

  localparam int MIN_DIV = 3;

  typedef enum logic [1:0] {
    PAR_NONE = 2'b00,
    PAR_EVEN = 2'b01,
    PAR_ODD  = 2'b10
  } parity_e;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_e;

  // The unused encoding 2'b11 behaves as no parity.
  function automatic parity_e decode_parity(input logic [1:0] mode);
    case (mode)
      2'b01:   return PAR_EVEN;
      2'b10:   return PAR_ODD;
      default: return PAR_NONE;
    endcase
  endfunction

endpackage

// File: rtl/uart_fifo_bridge_if.sv
// Byte-stream client port of the UART bridge: TX push side, RX pop side, FIFO levels.
// Valid/ready: a transfer happens on every clock edge where valid and ready are both 1;
// data is stable whenever valid is 1, and valid never waits on ready.
interface uart_fifo_bridge_if #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 16
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;
  logic [LW-1:0]        tx_level;
  logic [LW-1:0]        rx_level;

  modport master (
    output tx_data, tx_valid, rx_ready,
    input  tx_ready, rx_data, rx_valid, tx_level, rx_level
  );

  modport slave (
    input  tx_data, tx_valid, rx_ready,
    output tx_ready, rx_data, rx_valid, tx_level, rx_level
  );
endinterface

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO; pointers carry an extra wrap bit so full and empty come from the pointers alone.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level   = wr_ptr - rd_ptr;
  assign head    = mem[rd_ptr[AW-1:0]];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/uart_fifo_bridge.sv
// Buffered UART transceiver: runtime divisor and parity, TX/RX FIFOs, sticky line errors.
module uart_fifo_bridge
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DIV_WIDTH-1:0] cfg_div,
  input  logic [1:0]           cfg_parity,
  uart_fifo_bridge_if.slave    bus,
  input  logic                 err_clr,
  output logic                 err_frame,
  output logic                 err_parity,
  output logic                 err_overrun,
  output logic                 tx_busy,
  input  logic                 uart_rx,
  output logic                 uart_tx,
  output tx_state_e            dbg_tx_state,
  output rx_state_e            dbg_rx_state
);
  localparam int BW = $clog2(DATA_BITS);

  logic [DIV_WIDTH-1:0] div_eff;
  parity_e              cfg_par;

  assign div_eff = (cfg_div < DIV_WIDTH'(MIN_DIV)) ? DIV_WIDTH'(MIN_DIV) : cfg_div;
  assign cfg_par = decode_parity(cfg_parity);

  // ---------------- TX path ----------------
  logic [DATA_BITS-1:0] tx_head;
  logic                 tx_full, tx_empty, tx_pop;
  tx_state_e            tx_state;
  logic [DIV_WIDTH-1:0] tx_cnt, tx_div;
  parity_e              tx_par;
  logic [DATA_BITS-1:0] tx_sh;
  logic [BW-1:0]        tx_bit;
  logic                 tx_pbit;

  uart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (bus.tx_valid),
    .push_data (bus.tx_data),
    .pop       (tx_pop),
    .head      (tx_head),
    .full      (tx_full),
    .empty     (tx_empty),
    .level     (bus.tx_level)
  );

  // Popping in the last STOP cycle makes the next start bit follow with no idle gap.
  assign tx_pop = !tx_empty &&
                  ((tx_state == TX_IDLE) || (tx_state == TX_STOP && tx_cnt == '0));
  assign bus.tx_ready = !tx_full;
  assign tx_busy      = (tx_state != TX_IDLE) || !tx_empty;
  assign dbg_tx_state = tx_state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_div   <= '0;
      tx_par   <= PAR_NONE;
      tx_sh    <= '0;
      tx_bit   <= '0;
      tx_pbit  <= 1'b0;
      uart_tx  <= 1'b1;
    end else if (tx_pop) begin
      tx_state <= TX_START;
      tx_div   <= div_eff;
      tx_cnt   <= div_eff;
      tx_par   <= cfg_par;
      tx_sh    <= tx_head;
      tx_bit   <= '0;
      tx_pbit  <= (cfg_par == PAR_ODD) ? ~^tx_head : ^tx_head;
      uart_tx  <= 1'b0;
    end else if (tx_state != TX_IDLE) begin
      if (tx_cnt != '0) begin
        tx_cnt <= tx_cnt - DIV_WIDTH'(1);
      end else begin
        tx_cnt <= tx_div;
        case (tx_state)
          TX_START: begin
            tx_state <= TX_DATA;
            uart_tx  <= tx_sh[0];
          end
          TX_DATA: begin
            if (tx_bit == BW'(DATA_BITS - 1)) begin
              tx_bit <= '0;
              if (tx_par != PAR_NONE) begin
                tx_state <= TX_PARITY;
                uart_tx  <= tx_pbit;
              end else begin
                tx_state <= TX_STOP;
                uart_tx  <= 1'b1;
              end
            end else begin
              tx_bit  <= tx_bit + BW'(1);
              tx_sh   <= tx_sh >> 1;
              uart_tx <= tx_sh[1];
            end
          end
          TX_PARITY: begin
            tx_state <= TX_STOP;
            uart_tx  <= 1'b1;
          end
          default: begin
            tx_state <= TX_IDLE;
            uart_tx  <= 1'b1;
          end
        endcase
      end
    end
  end

  // ---------------- RX path ----------------
  logic                 rx_meta, rx_in, rx_prev;
  rx_state_e            rx_state;
  logic [DIV_WIDTH-1:0] rx_cnt, rx_div;
  parity_e              rx_par;
  logic [DATA_BITS-1:0] rx_sh;
  logic [BW-1:0]        rx_bit;
  logic                 rx_pbit;
  logic                 rx_push, rx_full, rx_empty;
  logic                 ev_frame, ev_parity, ev_overrun;

  uart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (rx_push),
    .push_data (rx_sh),
    .pop       (bus.rx_ready),
    .head      (bus.rx_data),
    .full      (rx_full),
    .empty     (rx_empty),
    .level     (bus.rx_level)
  );

  assign bus.rx_valid = !rx_empty;
  assign dbg_rx_state = rx_state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_in   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= uart_rx;
      rx_in   <= rx_meta;
      rx_prev <= rx_in;
    end
  end

  // Store/error pulses are registered at the stop-bit centre and take effect one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state   <= RX_IDLE;
      rx_cnt     <= '0;
      rx_div     <= '0;
      rx_par     <= PAR_NONE;
      rx_sh      <= '0;
      rx_bit     <= '0;
      rx_pbit    <= 1'b0;
      rx_push    <= 1'b0;
      ev_frame   <= 1'b0;
      ev_parity  <= 1'b0;
      ev_overrun <= 1'b0;
    end else begin
      rx_push    <= 1'b0;
      ev_frame   <= 1'b0;
      ev_parity  <= 1'b0;
      ev_overrun <= 1'b0;
      if (rx_state == RX_IDLE) begin
        if (rx_prev && !rx_in) begin
          rx_state <= RX_START;
          rx_div   <= div_eff;
          rx_cnt   <= div_eff >> 1;
          rx_par   <= cfg_par;
          rx_bit   <= '0;
        end
      end else if (rx_cnt != '0) begin
        rx_cnt <= rx_cnt - DIV_WIDTH'(1);
      end else begin
        rx_cnt <= rx_div;
        case (rx_state)
          RX_START: rx_state <= rx_in ? RX_IDLE : RX_DATA;
          RX_DATA: begin
            rx_sh <= {rx_in, rx_sh[DATA_BITS-1:1]};
            if (rx_bit == BW'(DATA_BITS - 1)) begin
              rx_bit   <= '0;
              rx_state <= (rx_par != PAR_NONE) ? RX_PARITY : RX_STOP;
            end else begin
              rx_bit <= rx_bit + BW'(1);
            end
          end
          RX_PARITY: begin
            rx_pbit  <= rx_in;
            rx_state <= RX_STOP;
          end
          default: begin
            rx_state  <= RX_IDLE;
            ev_frame  <= !rx_in;
            ev_parity <= (rx_par != PAR_NONE) &&
                         (rx_pbit != ((rx_par == PAR_ODD) ? ~^rx_sh : ^rx_sh));
            if (rx_full) ev_overrun <= 1'b1;
            else         rx_push    <= 1'b1;
          end
        endcase
      end
    end
  end

  // A new event outranks a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_frame   <= 1'b0;
      err_parity  <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      err_frame   <= (err_frame   && !err_clr) || ev_frame;
      err_parity  <= (err_parity  && !err_clr) || ev_parity;
      err_overrun <= (err_overrun && !err_clr) || ev_overrun;
    end
  end

endmodule

// File: tb/tb_uart_fifo_bridge.sv
// Directed bench for uart_fifo_bridge: serial waveform checks, loopback, error flags, overrun, reset abort.
module tb_uart_fifo_bridge;
  import uart_pkg::*;

  localparam int DATA_BITS  = 8;
  localparam int FIFO_DEPTH = 16;
  localparam int DIV_WIDTH  = 16;
  localparam int BIT_CLKS   = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [DIV_WIDTH-1:0] cfg_div = 16'd3;
  logic [1:0]           cfg_parity = 2'b00;
  logic                 err_clr = 1'b0;
  logic                 err_frame, err_parity, err_overrun, tx_busy;
  logic                 rx_drv = 1'b1;
  logic                 loop_en = 1'b0;
  logic                 rx_line;
  logic                 uart_tx;
  tx_state_e            dbg_tx_state;
  rx_state_e            dbg_rx_state;

  uart_fifo_bridge_if #(.DATA_BITS(DATA_BITS), .FIFO_DEPTH(FIFO_DEPTH)) bus ();

  assign rx_line = loop_en ? uart_tx : rx_drv;

  uart_fifo_bridge #(.DATA_BITS(DATA_BITS), .FIFO_DEPTH(FIFO_DEPTH), .DIV_WIDTH(DIV_WIDTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cfg_div      (cfg_div),
    .cfg_parity   (cfg_parity),
    .bus          (bus),
    .err_clr      (err_clr),
    .err_frame    (err_frame),
    .err_parity   (err_parity),
    .err_overrun  (err_overrun),
    .tx_busy      (tx_busy),
    .uart_rx      (rx_line),
    .uart_tx      (uart_tx),
    .dbg_tx_state (dbg_tx_state),
    .dbg_rx_state (dbg_rx_state)
  );

  // ---------------- scoreboard ----------------
  int               n_cmp = 0;
  int               n_fail = 0;
  logic [DATA_BITS-1:0] exp_q[$];
  logic             tx_bits[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_tx(input logic [7:0] d);
    check("push_tx_ready", bus.tx_ready, 1);
    bus.tx_data  = d;
    bus.tx_valid = 1'b1;
    @(negedge clk);
    bus.tx_valid = 1'b0;
  endtask

  task automatic drive_bit(input logic b);
    rx_drv = b;
    tick(BIT_CLKS);
  endtask

  task automatic send_frame(input logic [7:0] d, input bit par_en, input bit par_bit, input bit stop_bit);
    drive_bit(1'b0);
    for (int i = 0; i < DATA_BITS; i++) drive_bit(d[i]);
    if (par_en) drive_bit(par_bit);
    drive_bit(stop_bit);
    rx_drv = 1'b1;
  endtask

  task automatic clear_err();
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
  endtask

  task automatic add_frame_bits(input logic [7:0] d, input bit par_en, input bit odd);
    tx_bits.push_back(1'b0);
    for (int i = 0; i < DATA_BITS; i++) tx_bits.push_back(d[i]);
    if (par_en) tx_bits.push_back(odd ? ~^d : ^d);
    tx_bits.push_back(1'b1);
  endtask

  // Called on the first sample of a start bit; consumes tx_bits.
  task automatic sample_tx_bits(input string tag);
    int nb;
    nb = tx_bits.size();
    for (int i = 0; i < nb; i++) begin
      for (int j = 0; j < BIT_CLKS; j++) begin
        check($sformatf("%s_bit%0d_s%0d", tag, i, j), uart_tx, tx_bits[i]);
        @(negedge clk);
      end
    end
    tx_bits.delete();
  endtask

  task automatic pop_check(input string tag);
    int waited;
    logic [DATA_BITS-1:0] e;
    waited = 0;
    while (!bus.rx_valid && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.rx_valid) begin
      check({tag, "_timeout_rx_valid"}, bus.rx_valid, 1);
    end else if (exp_q.size() == 0) begin
      check({tag, "_unexpected_byte"}, bus.rx_valid, 0);
    end else begin
      e = exp_q.pop_front();
      check(tag, bus.rx_data, e);
      bus.rx_ready = 1'b1;
      @(negedge clk);
      bus.rx_ready = 1'b0;
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int lows;
    int w;
    logic [7:0] b;
    bus.tx_data  = '0;
    bus.tx_valid = 1'b0;
    bus.rx_ready = 1'b0;

    tick(3);
    rst_n = 1'b1;
    tick(2);
    check("rst_uart_tx", uart_tx, 1);
    check("rst_tx_ready", bus.tx_ready, 1);
    check("rst_rx_valid", bus.rx_valid, 0);
    check("rst_tx_level", bus.tx_level, 0);
    check("rst_rx_level", bus.rx_level, 0);
    check("rst_errors", {err_frame, err_parity, err_overrun}, 0);
    check("rst_tx_busy", tx_busy, 0);
    check("rst_tx_state", dbg_tx_state, TX_IDLE);
    check("rst_rx_state", dbg_rx_state, RX_IDLE);

    // 1: A5, no parity, start bit exactly two cycles after the push
    push_tx(8'hA5);
    check("t1_pre_start_line", uart_tx, 1);
    check("t1_tx_level", bus.tx_level, 1);
    check("t1_busy", tx_busy, 1);
    @(negedge clk);
    add_frame_bits(8'hA5, 1'b0, 1'b0);
    sample_tx_bits("t1");
    check("t1_idle_line", uart_tx, 1);
    check("t1_busy_done", tx_busy, 0);

    // 2: even parity loopback, three back-to-back frames
    tick(4);
    cfg_parity = 2'b01;
    loop_en    = 1'b1;
    add_frame_bits(8'h00, 1'b1, 1'b0);
    add_frame_bits(8'hFF, 1'b1, 1'b0);
    add_frame_bits(8'h3C, 1'b1, 1'b0);
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'h3C);
    fork
      begin
        push_tx(8'h00);
        push_tx(8'hFF);
        push_tx(8'h3C);
      end
      begin
        w = 0;
        while (uart_tx !== 1'b0 && w < 20) begin
          @(negedge clk);
          w++;
        end
        check("t2_start_seen", uart_tx, 0);
        sample_tx_bits("t2");
      end
    join
    pop_check("t2_rx0");
    pop_check("t2_rx1");
    pop_check("t2_rx2");
    check("t2_errors", {err_frame, err_parity, err_overrun}, 0);
    loop_en = 1'b0;

    // 3: odd parity with a wrong parity bit
    tick(8);
    cfg_parity = 2'b10;
    exp_q.push_back(8'h01);
    send_frame(8'h01, 1'b1, 1'b1, 1'b1);
    tick(8);
    check("t3_err_parity", err_parity, 1);
    check("t3_err_frame", err_frame, 0);
    pop_check("t3_rx");
    clear_err();
    check("t3_err_parity_cleared", err_parity, 0);

    // 4: overrun on the 17th frame
    cfg_parity = 2'b00;
    tick(4);
    check("t4_overrun_before", err_overrun, 0);
    for (int i = 0; i < FIFO_DEPTH + 1; i++) begin
      b = 8'($urandom_range(0, 255));
      if (i < FIFO_DEPTH) exp_q.push_back(b);
      send_frame(b, 1'b0, 1'b0, 1'b1);
    end
    tick(8);
    check("t4_rx_level", bus.rx_level, FIFO_DEPTH);
    check("t4_err_overrun", err_overrun, 1);
    check("t4_err_frame", err_frame, 0);
    for (int i = 0; i < FIFO_DEPTH; i++) pop_check($sformatf("t4_rx%0d", i));
    check("t4_rx_valid_drained", bus.rx_valid, 0);
    check("t4_rx_level_drained", bus.rx_level, 0);
    clear_err();

    // 5: one-clock glitch, then a frame with a low stop bit
    rx_drv = 1'b0;
    @(negedge clk);
    rx_drv = 1'b1;
    tick(20);
    check("t5_glitch_rx_valid", bus.rx_valid, 0);
    check("t5_glitch_errors", {err_frame, err_parity, err_overrun}, 0);
    check("t5_glitch_state", dbg_rx_state, RX_IDLE);
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 1'b0, 1'b0, 1'b0);
    tick(8);
    check("t5_err_frame", err_frame, 1);
    check("t5_err_parity", err_parity, 0);
    pop_check("t5_rx");
    clear_err();

    // 6: reset mid-frame with bytes queued
    for (int i = 0; i < 5; i++) push_tx(8'(8'h10 + i));
    tick(10);
    check("t6_busy_before", tx_busy, 1);
    rst_n = 1'b0;
    #1;
    check("t6_rst_uart_tx", uart_tx, 1);
    check("t6_rst_tx_level", bus.tx_level, 0);
    check("t6_rst_tx_ready", bus.tx_ready, 1);
    check("t6_rst_tx_busy", tx_busy, 0);
    check("t6_rst_tx_state", dbg_tx_state, TX_IDLE);
    tick(2);
    rst_n = 1'b1;
    lows = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (uart_tx !== 1'b1) lows++;
    end
    check("t6_silent_after_reset", lows, 0);
    check("t6_rx_valid", bus.rx_valid, 0);

    // 7: divisor below the minimum behaves as 3
    cfg_div = 16'd0;
    push_tx(8'h01);
    @(negedge clk);
    add_frame_bits(8'h01, 1'b0, 1'b0);
    sample_tx_bits("t7");
    check("t7_idle", dbg_tx_state, TX_IDLE);

    check("sb_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
